// File: rtl/isp_sobel_edge_if.sv
// Pixel-stream bundle for the Sobel edge stage: luma/sync in, gradient/edge out.
interface isp_sobel_edge_if;
  logic       in_vsync;
  logic       in_href;
  logic [7:0] in_y;
  logic [7:0] in_thresh;
  logic       out_vsync;
  logic       out_href;
  logic [7:0] out_grad;
  logic       out_bit;

  modport master (
    output in_vsync, in_href, in_y, in_thresh,
    input  out_vsync, out_href, out_grad, out_bit
  );

  modport slave (
    input  in_vsync, in_href, in_y, in_thresh,
    output out_vsync, out_href, out_grad, out_bit
  );
endinterface

// File: rtl/isp_sobel_edge.sv
// 3x3 Sobel gradient magnitude and thresholded edge bit on a luma stream,
// fixed 3-clock latency with sync signals carried alongside the data.
module isp_sobel_edge #(
  parameter int IMG_WIDTH_MAX  = 1024,
  parameter int IMG_HEIGHT_MAX = 1024
) (
  input  logic               clk,
  input  logic               rst_n,
  isp_sobel_edge_if.slave    bus
);

  localparam int DATA_W = 8;
  localparam int SUM_W  = 11;
  localparam int COL_W  = $clog2(IMG_WIDTH_MAX + 1);
  localparam int ROW_W  = $clog2(IMG_HEIGHT_MAX + 1);
  localparam int AW     = $clog2(IMG_WIDTH_MAX);
  localparam logic [COL_W-1:0] COL_MAX = COL_W'(IMG_WIDTH_MAX);
  localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(IMG_HEIGHT_MAX);

  function automatic logic signed [SUM_W-1:0] widen(input logic [DATA_W-1:0] p);
    return $signed({{(SUM_W-DATA_W){1'b0}}, p});
  endfunction

  function automatic logic [SUM_W-1:0] abs_val(input logic signed [SUM_W-1:0] x);
    return x[SUM_W-1] ? $unsigned(-x) : $unsigned(x);
  endfunction

  function automatic logic [DATA_W-1:0] sat_u8(input logic [SUM_W-1:0] m);
    return (|m[SUM_W-1:DATA_W]) ? {DATA_W{1'b1}} : m[DATA_W-1:0];
  endfunction

  logic             vsync_d, href_d;
  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row, row_cur;
  logic             vsync_rise, col_ok;
  logic [AW-1:0]    addr;

  assign vsync_rise = bus.in_vsync & ~vsync_d;
  // A new frame masks the current pixel immediately, even mid-line.
  assign row_cur    = vsync_rise ? '0 : row;
  assign col_ok     = (col < COL_MAX);
  assign addr       = col[AW-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_d <= 1'b0;
      href_d  <= 1'b0;
      col     <= '0;
      row     <= '0;
    end else begin
      vsync_d <= bus.in_vsync;
      href_d  <= bus.in_href;
      if (!bus.in_href)
        col <= '0;
      else if (col != COL_MAX)
        col <= col + 1'b1;
      if (vsync_rise)
        row <= '0;
      else if (href_d && !bus.in_href && (row != ROW_MAX))
        row <= row + 1'b1;
    end
  end

  // S1: line-buffer read, window shift ([0] = column c-2, [2] = column c)
  logic [DATA_W-1:0] lb0 [IMG_WIDTH_MAX];
  logic [DATA_W-1:0] lb1 [IMG_WIDTH_MAX];
  logic [2:0][DATA_W-1:0] top_p0, mid_p0, bot_p0;
  logic vld_p0, vsync_p0, href_p0;

  always_ff @(posedge clk) begin
    top_p0 <= {lb1[addr], top_p0[2:1]};
    mid_p0 <= {lb0[addr], mid_p0[2:1]};
    bot_p0 <= {bus.in_y, bot_p0[2:1]};
    if (bus.in_href && col_ok) begin
      lb1[addr] <= lb0[addr];
      lb0[addr] <= bus.in_y;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0   <= 1'b0;
      vsync_p0 <= 1'b0;
      href_p0  <= 1'b0;
    end else begin
      vld_p0   <= bus.in_href && (row_cur >= ROW_W'(2)) && (col >= COL_W'(2)) && col_ok;
      vsync_p0 <= bus.in_vsync;
      href_p0  <= bus.in_href;
    end
  end

  // S2: horizontal and vertical gradient sums
  logic signed [SUM_W-1:0] gx_c, gy_c, gx_p1, gy_p1;
  logic vld_p1, vsync_p1, href_p1;

  always_comb begin
    gx_c = (widen(top_p0[2]) + (widen(mid_p0[2]) <<< 1) + widen(bot_p0[2]))
         - (widen(top_p0[0]) + (widen(mid_p0[0]) <<< 1) + widen(bot_p0[0]));
    gy_c = (widen(bot_p0[0]) + (widen(bot_p0[1]) <<< 1) + widen(bot_p0[2]))
         - (widen(top_p0[0]) + (widen(top_p0[1]) <<< 1) + widen(top_p0[2]));
  end

  always_ff @(posedge clk) begin
    gx_p1 <= gx_c;
    gy_p1 <= gy_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1   <= 1'b0;
      vsync_p1 <= 1'b0;
      href_p1  <= 1'b0;
    end else begin
      vld_p1   <= vld_p0;
      vsync_p1 <= vsync_p0;
      href_p1  <= href_p0;
    end
  end

  // S3: magnitude, saturation, threshold compare
  logic [SUM_W-1:0] mag_c;
  assign mag_c = abs_val(gx_p1) + abs_val(gy_p1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_vsync <= 1'b0;
      bus.out_href  <= 1'b0;
      bus.out_grad  <= '0;
      bus.out_bit   <= 1'b0;
    end else begin
      bus.out_vsync <= vsync_p1;
      bus.out_href  <= href_p1;
      bus.out_grad  <= vld_p1 ? sat_u8(mag_c) : '0;
      bus.out_bit   <= vld_p1 && (mag_c > {{(SUM_W-DATA_W){1'b0}}, bus.in_thresh});
    end
  end

endmodule
